// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader and its readback deserialiser.
package ccff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2
  } ccff_state_e;

  // Width needed to hold values 0..max_val inclusive.
  function automatic int ccff_cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccff_rb_deser.sv
// Collects ccff_tail bits LSB-first into words; rb_valid pulses the cycle after a word
// (or the final partial word) completes. No backpressure: the consumer must take every pulse.
module ccff_rb_deser
  import ccff_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              clear_i,
  input  logic              sample_i,
  input  logic              bit_i,
  input  logic              last_i,
  output logic [WORD_W-1:0] rb_data_o,
  output logic              rb_valid_o
);

  localparam int WC_W = ccff_cnt_w(WORD_W - 1);
  localparam logic [WC_W-1:0] WORD_LAST = WC_W'(WORD_W - 1);

  logic [WORD_W-1:0] acc_q, acc_d, data_q, data_d, merged;
  logic [WC_W-1:0]   cnt_q, cnt_d;
  logic              valid_q, valid_d, word_end;

  always_comb begin
    merged        = acc_q;
    merged[cnt_q] = bit_i;
    word_end      = (cnt_q == WORD_LAST) || last_i;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    valid_d       = 1'b0;
    // Clear beats sampling so an aborted load never emits a partial word.
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (sample_i) begin
      if (word_end) begin
        acc_d   = '0;
        cnt_d   = '0;
        data_d  = merged;
        valid_d = 1'b1;
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + WC_W'(1);
      end
    end
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign rb_data_o  = data_q;
  assign rb_valid_o = valid_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises cfg words onto ccff_head (LSB first), 1 cycle handshake->shift, zero-bubble between words;
// cfg_valid low simply stalls the chain (shift_en=0), readback words come back from ccff_tail.
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = ccff_cnt_w(CHAIN_LEN);
  localparam int WC_W  = ccff_cnt_w(WORD_W - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WC_W-1:0]  WORD_LAST = WC_W'(WORD_W - 1);

  ccff_state_e       state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [WC_W-1:0]   wordcnt_q, wordcnt_d;
  logic              done_q, done_d;
  logic              last_bit, last_word, rb_clear;

  assign last_bit  = (bitcnt_q == BIT_LAST);
  assign last_word = (wordcnt_q == WORD_LAST);

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bitcnt_d  = bitcnt_q;
    wordcnt_d = wordcnt_q;
    done_d    = done_q;
    cfg_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d  = ST_FETCH;
          done_d   = 1'b0;
          bitcnt_d = '0;
        end
      end
      ST_FETCH: begin
        cfg_ready = !abort;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cfg_valid) begin
          sreg_d    = cfg_data;
          wordcnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sreg_d    = sreg_q >> 1;
        bitcnt_d  = bitcnt_q + CNT_W'(1);
        wordcnt_d = wordcnt_q + WC_W'(1);
        if (abort) begin
          state_d = ST_IDLE;
        end else if (last_bit) begin
          // Chain-length limit wins over word boundary: upper bits of a partial word are dropped.
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (last_word) begin
          cfg_ready = 1'b1;
          if (cfg_valid) begin
            sreg_d    = cfg_data;
            wordcnt_d = '0;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      bitcnt_q  <= '0;
      wordcnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bitcnt_q  <= bitcnt_d;
      wordcnt_q <= wordcnt_d;
      done_q    <= done_d;
    end
  end

  assign ccff_head     = sreg_q[0];
  assign ccff_shift_en = (state_q == ST_SHIFT);
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign rb_clear      = abort || ((state_q == ST_IDLE) && start);

  ccff_rb_deser #(
    .WORD_W (WORD_W)
  ) u_rb_deser (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .clear_i    (rb_clear),
    .sample_i   (ccff_shift_en),
    .bit_i      (ccff_tail),
    .last_i     (ccff_shift_en && last_bit),
    .rb_data_o  (rb_data),
    .rb_valid_o (rb_valid)
  );

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench: two loader instances (16- and 10-flop chains) each driving a behavioural chain model.
module tb_ccff_bitstream_loader;

  logic clk = 1'b0;
  logic prog_reset = 1'b1;
  logic sel = 1'b0;
  logic start = 1'b0, abort = 1'b0, cfg_valid = 1'b0;
  logic [7:0] cfg_data = 8'h00;

  logic rdy16, head16, se16, rbv16, busy16, done16;
  logic rdy10, head10, se10, rbv10, busy10, done10;
  logic [7:0] rbd16, rbd10;
  logic [15:0] chain16;
  logic [9:0]  chain10;
  logic pre_ld16 = 1'b1, pre_ld10 = 1'b1;
  logic [15:0] pre_val16 = 16'hBEEF;
  logic [9:0]  pre_val10 = 10'h2B5;

  always #5 clk = ~clk;

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(16)) dut16 (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start & ~sel), .abort(abort & ~sel),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid & ~sel), .cfg_ready(rdy16),
    .ccff_head(head16), .ccff_shift_en(se16), .ccff_tail(chain16[0]),
    .rb_data(rbd16), .rb_valid(rbv16), .busy(busy16), .done(done16));

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(10)) dut10 (
    .prog_clk(clk), .prog_reset(prog_reset), .start(start & sel), .abort(abort & sel),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid & sel), .cfg_ready(rdy10),
    .ccff_head(head10), .ccff_shift_en(se10), .ccff_tail(chain10[0]),
    .rb_data(rbd10), .rb_valid(rbv10), .busy(busy10), .done(done10));

  // Chain models: head enters at the MSB, the tail is bit 0.
  always @(posedge clk) begin
    if (pre_ld16) chain16 <= pre_val16;
    else if (se16) chain16 <= {head16, chain16[15:1]};
    if (pre_ld10) chain10 <= pre_val10;
    else if (se10) chain10 <= {head10, chain10[9:1]};
  end

  wire        rdy_m   = sel ? rdy10  : rdy16;
  wire        se_m    = sel ? se10   : se16;
  wire        busy_m  = sel ? busy10 : busy16;
  wire        done_m  = sel ? done10 : done16;
  wire        rbv_m   = sel ? rbv10  : rbv16;
  wire [7:0]  rbd_m   = sel ? rbd10  : rbd16;
  wire [15:0] chain_m = sel ? {6'd0, chain10} : chain16;

  int rb_total = 0;
  logic [7:0] rb_log [0:63];
  always @(negedge clk) begin
    if (rbv_m) begin
      rb_log[rb_total[5:0]] <= rbd_m;
      rb_total <= rb_total + 1;
    end
  end

  int n_cmp = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int t_shifts, t_acc, t_gap, first_hs, first_sh, last_sh, done_cyc, rb0;
  logic [15:0] g0, gl;

  task automatic do_load(input logic [7:0] w0, input logic [7:0] w1, input int drop, input int start_at);
    int wi = 0, hold = 0;
    bit sp = 0;
    t_shifts = 0; t_acc = 0; t_gap = 0;
    first_hs = -1; first_sh = -1; last_sh = -1; done_cyc = -1;
    g0 = '0; gl = '0; rb0 = rb_total;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      start = (start_at > 0) && (t_shifts == start_at) && !sp;
      if (start) sp = 1;
      if (wi == 0) begin cfg_valid = 1'b1; cfg_data = w0; end
      else if (wi == 1 && hold >= drop) begin cfg_valid = 1'b1; cfg_data = w1; end
      else cfg_valid = 1'b0;
      #1;
      if (done_m) begin done_cyc = c; break; end
      if (se_m) begin
        t_shifts++;
        if (first_sh < 0) first_sh = c;
        last_sh = c;
      end else if (first_sh >= 0) begin
        t_gap++;
        if (t_gap == 1) g0 = chain_m;
        gl = chain_m;
      end
      if (cfg_valid && rdy_m) begin
        if (first_hs < 0) first_hs = c;
        wi++; t_acc++;
      end
      if (wi == 1 && !cfg_valid) hold++;
      @(negedge clk);
    end
    start = 1'b0; cfg_valid = 1'b0;
    chk("load_done_seen", done_cyc >= 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ctl16", {rdy16, se16, head16, rbv16, busy16, done16}, 0);
    chk("rst_rb16", rbd16, 0);
    chk("rst_ctl10", {rdy10, se10, head10, rbv10, busy10, done10}, 0);
    chk("rst_rb10", rbd10, 0);
    prog_reset = 1'b0; pre_ld16 = 1'b0; pre_ld10 = 1'b0;

    // 1: two words, valid held high, no bubble
    do_load(8'hA5, 8'h3C, 0, 0);
    chk("t1_shifts", t_shifts, 16);
    chk("t1_gap", t_gap, 0);
    chk("t1_accepted", t_acc, 2);
    chk("t1_hs_to_shift", first_sh - first_hs, 1);
    chk("t1_shift_to_done", done_cyc - last_sh, 1);
    chk("t1_chain", chain16, 16'h3CA5);
    chk("t1_busy", busy16, 0);
    chk("t1_rb_count", rb_total - rb0, 2);
    chk("t1_rb0", rb_log[rb0[5:0]], 8'hEF);
    chk("t1_rb1", rb_log[rb0[5:0] + 6'd1], 8'hBE);

    // 2: 10-flop chain, final partial word truncated
    sel = 1'b1;
    do_load(8'hFF, 8'hFF, 0, 0);
    chk("t2_shifts", t_shifts, 10);
    chk("t2_accepted", t_acc, 2);
    chk("t2_chain", chain10, 10'h3FF);
    chk("t2_done", done10, 1);
    chk("t2_rb_count", rb_total - rb0, 2);
    chk("t2_rb0", rb_log[rb0[5:0]], 8'hB5);
    chk("t2_rb_partial", rb_log[rb0[5:0] + 6'd1], 8'h02);
    sel = 1'b0;

    // 3: readback of a preloaded image
    @(negedge clk); pre_val16 = 16'h1234; pre_ld16 = 1'b1;
    @(negedge clk); pre_ld16 = 1'b0;
    do_load(8'h00, 8'h00, 0, 0);
    chk("t3_rb_count", rb_total - rb0, 2);
    chk("t3_rb0", rb_log[rb0[5:0]], 8'h34);
    chk("t3_rb1", rb_log[rb0[5:0] + 6'd1], 8'h12);
    chk("t3_chain", chain16, 16'h0000);

    // 4: host stalls between words; chain must hold during the gap
    do_load(8'h5A, 8'hC3, 12, 0);
    chk("t4_gap", t_gap, 5);
    chk("t4_gap_first", g0, 16'h5A00);
    chk("t4_gap_last", gl, 16'h5A00);
    chk("t4_shifts", t_shifts, 16);
    chk("t4_chain", chain16, 16'hC35A);

    // 5: abort during the sixth shift cycle
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cfg_data = 8'h0F; cfg_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (se16) n++;
      @(negedge clk);
      cfg_valid = 1'b0;
      if (n == 5) break;
    end
    chk("t5_reached5", n, 5);
    abort = 1'b1; rb0 = rb_total;
    @(negedge clk); abort = 1'b0;
    #1;
    chk("t5_shift_en", se16, 0);
    chk("t5_busy", busy16, 0);
    chk("t5_done", done16, 0);
    chk("t5_ready", rdy16, 0);
    repeat (3) @(negedge clk);
    chk("t5_no_rb", rb_total - rb0, 0);
    chk("t5_chain_partial", chain16, 16'h3F0D);
    do_load(8'h81, 8'h7E, 0, 0);
    chk("t5_reload_chain", chain16, 16'h7E81);
    chk("t5_reload_rb0", rb_log[rb0[5:0]], 8'h0D);
    chk("t5_reload_rb1", rb_log[rb0[5:0] + 6'd1], 8'h3F);

    // 6: start while busy is ignored; async reset mid-shift
    do_load(8'h11, 8'h22, 0, 3);
    chk("t6_busy_start_shifts", t_shifts, 16);
    chk("t6_busy_start_chain", chain16, 16'h2211);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; cfg_data = 8'h99; cfg_valid = 1'b1;
    @(negedge clk); cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("t6_pre_rst_shift", se16, 1);
    prog_reset = 1'b1;
    #1;
    chk("t6_arst_ctl", {rdy16, se16, head16, rbv16, busy16, done16}, 0);
    chk("t6_arst_rb", rbd16, 0);
    @(negedge clk); prog_reset = 1'b0;
    do_load(8'h44, 8'h55, 0, 0);
    chk("t6_recover_chain", chain16, 16'h5544);
    chk("t6_recover_shifts", t_shifts, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
